// File: rtl/rv32_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rv32_bus_pkg
// Shared types and constants for the rv32 memory arbiter slice.
//   state_e : arbiter sequencer states (IDLE, ISSUE, WAIT_RSP)
//   owner_e : which requester owns the in-flight transaction (OWN_IF, OWN_LS)
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
//   be_width() : byte-enable width derived from a data width
// -----------------------------------------------------------------------------
package rv32_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // One enable bit per data byte.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    localparam int BE_W_DEF = be_width(DATA_W_DEF);

endpackage

// File: rtl/rv32_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// rv32_mem_arbiter_if
// Bundles the three buses around the arbiter: instruction fetch (if_*),
// load/store (ls_*) and the single memory port (mem_*).
//
// Handshake semantics (all request channels):
//   A request transfers on a cycle where valid && ready are both high at the
//   rising clock edge. The requester holds valid and all payload fields stable
//   until that edge; it may drop valid before a transfer without side effects.
//   Responses (*_rsp_valid) are single-cycle pulses with no back-pressure.
//
// Modports:
//   slave  : the arbiter's view (takes requests, drives memory side)
//   master : the environment's view (requesters + memory model)
// -----------------------------------------------------------------------------
interface rv32_mem_arbiter_if
    import rv32_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int BE_W = be_width(DATA_W);

    // Instruction fetch
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_rdata;
    logic              if_rsp_err;

    // Load/store
    logic              ls_req_valid;
    logic              ls_req_we;
    logic [BE_W-1:0]   ls_req_be;
    logic [ADDR_W-1:0] ls_req_addr;
    logic [DATA_W-1:0] ls_req_wdata;
    logic              ls_req_ready;
    logic              ls_rsp_valid;
    logic [DATA_W-1:0] ls_rsp_rdata;
    logic              ls_rsp_err;

    // Memory port
    logic              mem_req_valid;
    logic              mem_req_we;
    logic [BE_W-1:0]   mem_req_be;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
        input  ls_req_valid, ls_req_we, ls_req_be, ls_req_addr, ls_req_wdata,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata, ls_rsp_err,
        output mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
        output ls_req_valid, ls_req_we, ls_req_be, ls_req_addr, ls_req_wdata,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata, ls_rsp_err,
        input  mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

endinterface

// File: rtl/rv32_mem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rv32_arb_pick
// Two-way grant picker for the memory arbiter. Purely combinational.
//   i_if_valid   : fetch request pending
//   i_ls_valid   : load/store request pending
//   i_last_owner : owner of the most recently completed transaction
//   o_winner     : requester to grant (only meaningful when a valid is high)
//
// Build option RV32_ARB_ROUND_ROBIN_EN:
//   defined   - on a tie the requester that did not go last wins
//   undefined - load/store always wins a tie; i_last_owner is ignored
// -----------------------------------------------------------------------------
module rv32_arb_pick
    import rv32_bus_pkg::*;
(
    input  logic   i_if_valid,
    input  logic   i_ls_valid,
    input  owner_e i_last_owner,
    output owner_e o_winner
);

`ifdef RV32_ARB_ROUND_ROBIN_EN

    always_comb begin
        o_winner = OWN_LS;
        if (i_if_valid && i_ls_valid) begin
            o_winner = (i_last_owner == OWN_LS) ? OWN_IF : OWN_LS;
        end else if (i_if_valid) begin
            o_winner = OWN_IF;
        end
    end

`else

    // Fixed priority: fetch only wins when load/store is idle.
    always_comb begin
        o_winner = OWN_LS;
        if (i_if_valid && !i_ls_valid) begin
            o_winner = OWN_IF;
        end
    end

    // History is not consulted in fixed-priority mode.
    logic w_unused_last_owner;
    assign w_unused_last_owner = (i_last_owner == OWN_LS);

`endif

endmodule

// File: rtl/rv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// rv32_mem_arbiter
// Shares the single memory port of processor_top between instruction fetch
// and load/store. One transaction in flight at a time:
//   IDLE     : pick a winner, acknowledge it (req_ready) and capture its fields
//   ISSUE    : present the registered request until the memory accepts it
//   WAIT_RSP : route mem_rsp_valid back to the owner, or report an error
//              response after TIMEOUT cycles with no answer
//
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous, active-low reset
//   bus         : rv32_mem_arbiter_if.slave (fetch, load/store, memory buses)
//   busy        : high whenever the sequencer is not in IDLE
//   o_dbg_state : current sequencer state for observation
//
// Parameters: ADDR_W, DATA_W (byte enables are DATA_W/8), TIMEOUT (>= 1).
//
// Build option RV32_ARB_ROUND_ROBIN_EN: alternate grants on ties using the
// owner of the last completed transaction; otherwise load/store has fixed
// priority and no history is kept.
// -----------------------------------------------------------------------------
module rv32_mem_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
)(
    input  logic                  clk,
    input  logic                  rst,
    rv32_mem_arbiter_if.slave     bus,
    output logic                  busy,
    output state_e                o_dbg_state
);

    localparam int BE_W  = be_width(DATA_W);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // -------------------------------------------------------------------------
    // State and captured request
    // -------------------------------------------------------------------------
    state_e            r_state;
    owner_e            r_owner;
    logic              r_mem_req_valid;
    logic              r_we;
    logic [BE_W-1:0]   r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;

    owner_e            w_last_owner;
    owner_e            w_winner;

`ifdef RV32_ARB_ROUND_ROBIN_EN
    owner_e            r_last_owner;
    assign w_last_owner = r_last_owner;
`else
    assign w_last_owner = OWN_LS;
`endif

    rv32_arb_pick u_pick (
        .i_if_valid   (bus.if_req_valid),
        .i_ls_valid   (bus.ls_req_valid),
        .i_last_owner (w_last_owner),
        .o_winner     (w_winner)
    );

    // -------------------------------------------------------------------------
    // Grant: combinational in IDLE so the requester sees ready in the same
    // cycle it is captured. Gated by rst so nothing is acknowledged while the
    // block is held in reset.
    // -------------------------------------------------------------------------
    logic w_grant;
    assign w_grant = rst && (r_state == IDLE) && (bus.if_req_valid || bus.ls_req_valid);

    assign bus.if_req_ready = w_grant && (w_winner == OWN_IF);
    assign bus.ls_req_ready = w_grant && (w_winner == OWN_LS);

    // -------------------------------------------------------------------------
    // Completion. A real response in the same cycle the counter expires is
    // still delivered as data rather than as an error.
    // -------------------------------------------------------------------------
    logic              w_wait;
    logic              w_rsp_hit;
    logic              w_timeout;
    logic              w_done;
    logic [DATA_W-1:0] w_rsp_data;

    assign w_wait     = (r_state == WAIT_RSP);
    assign w_rsp_hit  = w_wait && bus.mem_rsp_valid;
    assign w_timeout  = w_wait && !bus.mem_rsp_valid && (r_cnt == TIMEOUT_C);
    assign w_done     = w_rsp_hit || w_timeout;
    assign w_rsp_data = w_rsp_hit ? bus.mem_rsp_rdata : '0;

    // Responses go only to the owner; data is forced to zero when not valid.
    assign bus.if_rsp_valid = w_done && (r_owner == OWN_IF);
    assign bus.if_rsp_rdata = bus.if_rsp_valid ? w_rsp_data : '0;
    assign bus.if_rsp_err   = bus.if_rsp_valid && w_timeout;

    assign bus.ls_rsp_valid = w_done && (r_owner == OWN_LS);
    assign bus.ls_rsp_rdata = bus.ls_rsp_valid ? w_rsp_data : '0;
    assign bus.ls_rsp_err   = bus.ls_rsp_valid && w_timeout;

    // Memory request straight from registers: stable while waiting for ready.
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_req_we    = r_we;
    assign bus.mem_req_be    = r_be;
    assign bus.mem_req_addr  = r_addr;
    assign bus.mem_req_wdata = r_wdata;

    assign busy        = (r_state != IDLE);
    assign o_dbg_state = r_state;

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_owner         <= OWN_IF;
            r_mem_req_valid <= 1'b0;
            r_we            <= 1'b0;
            r_be            <= '0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_cnt           <= '0;
`ifdef RV32_ARB_ROUND_ROBIN_EN
            r_last_owner    <= OWN_IF;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state         <= ISSUE;
                        r_owner         <= w_winner;
                        r_mem_req_valid <= 1'b1;
                        if (w_winner == OWN_LS) begin
                            r_we    <= bus.ls_req_we;
                            r_be    <= bus.ls_req_be;
                            r_addr  <= bus.ls_req_addr;
                            r_wdata <= bus.ls_req_wdata;
                        end else begin
                            // Fetches are always full-word reads.
                            r_we    <= 1'b0;
                            r_be    <= '1;
                            r_addr  <= bus.if_req_addr;
                            r_wdata <= '0;
                        end
                    end
                end

                ISSUE: begin
                    if (bus.mem_req_ready) begin
                        r_state         <= WAIT_RSP;
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                    end
                end

                WAIT_RSP: begin
                    if (w_done) begin
                        r_state      <= IDLE;
`ifdef RV32_ARB_ROUND_ROBIN_EN
                        r_last_owner <= r_owner;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state         <= IDLE;
                    r_mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rv32_mem_arbiter
// Directed bench for rv32_mem_arbiter: a table of single transactions plus
// hand-written sequences for contention, timeout and reset mid-transaction.
// -----------------------------------------------------------------------------
module tb_rv32_mem_arbiter;
    import rv32_bus_pkg::*;

    localparam int TIMEOUT = 15;

    logic   clk;
    logic   rst;
    logic   busy;
    state_e dbg_state;

    rv32_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    rv32_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_chk;
    int          n_err;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic drive_if(input logic v, input logic [31:0] a);
        bus.if_req_valid = v;
        bus.if_req_addr  = a;
    endtask

    task automatic drive_ls(input logic v, input logic we, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] wd);
        bus.ls_req_valid = v;
        bus.ls_req_we    = we;
        bus.ls_req_be    = be;
        bus.ls_req_addr  = a;
        bus.ls_req_wdata = wd;
    endtask

    function automatic logic rdy_of(input owner_e o);
        return (o == OWN_LS) ? bus.ls_req_ready : bus.if_req_ready;
    endfunction

    function automatic logic rsp_of(input owner_e o);
        return (o == OWN_LS) ? bus.ls_rsp_valid : bus.if_rsp_valid;
    endfunction

    function automatic logic [31:0] rdata_of(input owner_e o);
        return (o == OWN_LS) ? bus.ls_rsp_rdata : bus.if_rsp_rdata;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_ls;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_rdata;
        int          stall;      // cycles mem_req_ready stays low in ISSUE
        int          rsp_dly;    // WAIT_RSP cycles before the memory answers
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    // One complete transaction: grant, issue (with optional stall), response.
    task automatic run_vec(input vec_t v, input string tag);
        owner_e own;
        owner_e oth;
        own = v.is_ls ? OWN_LS : OWN_IF;
        oth = v.is_ls ? OWN_IF : OWN_LS;

        cyc;
        if (v.is_ls) drive_ls(1'b1, v.we, v.be, v.addr, v.wdata);
        else         drive_if(1'b1, v.addr);
        #1;
        chk({tag, " req_ready"}, rdy_of(own), 1);
        chk({tag, " other_ready"}, rdy_of(oth), 0);
        chk({tag, " idle_mem_valid"}, bus.mem_req_valid, 0);
        exp_q.push_back(v.exp_rdata);

        cyc;
        bus.if_req_valid  = 1'b0;
        bus.ls_req_valid  = 1'b0;
        bus.mem_req_ready = (v.stall == 0);
        #1;
        chk({tag, " mem_valid"}, bus.mem_req_valid, 1);
        chk({tag, " mem_addr"}, bus.mem_req_addr, v.addr);
        chk({tag, " mem_we"}, bus.mem_req_we, v.exp_we);
        chk({tag, " mem_be"}, bus.mem_req_be, v.exp_be);
        chk({tag, " mem_wdata"}, bus.mem_req_wdata, v.exp_wdata);
        chk({tag, " busy"}, busy, 1);

        for (int s = 0; s < v.stall; s++) begin
            cyc;
            bus.mem_req_ready = (s == v.stall - 1);
            #1;
            chk({tag, " stall_valid"}, bus.mem_req_valid, 1);
            chk({tag, " stall_addr"}, bus.mem_req_addr, v.addr);
            chk({tag, " stall_wdata"}, bus.mem_req_wdata, v.exp_wdata);
        end

        cyc;
        bus.mem_req_ready = 1'b0;
        #1;
        chk({tag, " wait_mem_valid"}, bus.mem_req_valid, 0);
        for (int d = 0; d < v.rsp_dly; d++) begin
            chk({tag, " early_rsp"}, rsp_of(own), 0);
            cyc;
            #1;
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = v.mem_rdata;
        #1;
        chk({tag, " rsp_valid"}, rsp_of(own), 1);
        chk({tag, " rsp_rdata"}, rdata_of(own), exp_q.pop_front());
        chk({tag, " rsp_err"}, v.is_ls ? bus.ls_rsp_err : bus.if_rsp_err, 0);
        chk({tag, " other_rsp"}, rsp_of(oth), 0);

        cyc;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'h0;
        #1;
        chk({tag, " done_busy"}, busy, 0);
        chk({tag, " done_rsp"}, rsp_of(own), 0);
    endtask

    // ---------------- test ----------------
    initial begin
        owner_e first;
        owner_e second;
        logic [31:0] first_addr;
        logic [31:0] second_addr;
        int k;
        vec_t fresh;

        n_chk = 0;
        n_err = 0;

        //             ls we be       addr          wdata         mem_rdata     st dl ewe ebe      ewdata        erdata
        vecs[0] = '{1'b0, 1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'h0050_0093, 0, 0, 1'b0, 4'hF,    32'h0,         32'h0050_0093};
        vecs[1] = '{1'b1, 1'b0, 4'hF,    32'h0000_0100, 32'h0,         32'h1234_5678, 0, 2, 1'b0, 4'hF,    32'h0,         32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 4'b0011, 32'h0000_0104, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 0, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 4'h0,    32'h0000_0020, 32'h0,         32'h1111_2222, 4, 1, 1'b0, 4'hF,    32'h0,         32'h1111_2222};
        vecs[4] = '{1'b1, 1'b0, 4'b0100, 32'h0000_0200, 32'h55AA_0000, 32'hA5A5_A5A5, 1, 0, 1'b0, 4'b0100, 32'h55AA_0000, 32'hA5A5_A5A5};

        rst = 1'b0;
        drive_if(1'b1, 32'h0000_0044);
        drive_ls(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'h0;

        // Reset state, including no grant while held in reset.
        repeat (2) cyc;
        #1;
        chk("reset busy", busy, 0);
        chk("reset state", 32'(dbg_state), 32'(IDLE));
        chk("reset if_ready", bus.if_req_ready, 0);
        chk("reset mem_valid", bus.mem_req_valid, 0);
        chk("reset mem_be", bus.mem_req_be, 0);
        chk("reset mem_addr", bus.mem_req_addr, 0);
        cyc;
        drive_if(1'b0, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- Simultaneous requests (previous winner was load/store) ----
`ifdef RV32_ARB_ROUND_ROBIN_EN
        first = OWN_IF;  second = OWN_LS;
        first_addr = 32'h20; second_addr = 32'h100;
`else
        first = OWN_LS;  second = OWN_IF;
        first_addr = 32'h100; second_addr = 32'h20;
`endif
        cyc;
        drive_if(1'b1, 32'h0000_0020);
        drive_ls(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
        #1;
        chk("both first_ready", rdy_of(first), 1);
        chk("both second_ready", rdy_of(second), 0);
        cyc;
        if (first == OWN_LS) bus.ls_req_valid = 1'b0; else bus.if_req_valid = 1'b0;
        #1;
        chk("both issue_addr", bus.mem_req_addr, first_addr);
        chk("both issue_no_ready", rdy_of(second), 0);
        cyc;
        bus.mem_req_ready = 1'b1;
        #1;
        chk("both stall_no_ready", rdy_of(second), 0);
        cyc;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h0000_AAAA;
        #1;
        chk("both wait_no_ready", rdy_of(second), 0);
        chk("both first_rsp", rsp_of(first), 1);
        chk("both first_rdata", rdata_of(first), 32'h0000_AAAA);
        chk("both second_no_rsp", rsp_of(second), 0);
        cyc;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'h0;
        #1;
        chk("both second_ready", rdy_of(second), 1);
        cyc;
        bus.if_req_valid  = 1'b0;
        bus.ls_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1;
        chk("both second_addr", bus.mem_req_addr, second_addr);
        chk("both second_be", bus.mem_req_be, 32'hF);
        cyc;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h0000_BBBB;
        #1;
        chk("both second_rsp", rsp_of(second), 1);
        chk("both second_rdata", rdata_of(second), 32'h0000_BBBB);
        cyc;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'h0;

        // ---- Timeout: memory accepts but never answers ----
        cyc;
        drive_if(1'b1, 32'h0000_0040);
        #1;
        chk("tmo if_ready", bus.if_req_ready, 1);
        exp_q.push_back(32'h0);
        cyc;
        bus.if_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1;
        chk("tmo mem_valid", bus.mem_req_valid, 1);
        cyc;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_rdata = 32'hBAD0_BAD0;
        #1;
        k = 0;
        while (!bus.if_rsp_valid && k < 40) begin
            cyc;
            #1;
            k++;
        end
        chk("tmo latency", k, TIMEOUT);
        chk("tmo rsp_valid", bus.if_rsp_valid, 1);
        chk("tmo rsp_err", bus.if_rsp_err, 1);
        chk("tmo rsp_rdata", bus.if_rsp_rdata, exp_q.pop_front());
        chk("tmo ls_rsp", bus.ls_rsp_valid, 0);
        cyc;
        bus.mem_rsp_valid = 1'b1;
        #1;
        chk("late rsp_ignored", bus.if_rsp_valid, 0);
        chk("late busy", busy, 0);
        cyc;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'h0;

        // ---- Reset during WAIT_RSP ----
        cyc;
        drive_ls(1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0);
        #1;
        chk("rstmid ls_ready", bus.ls_req_ready, 1);
        cyc;
        bus.ls_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        cyc;
        bus.mem_req_ready = 1'b0;
        #1;
        chk("rstmid busy_before", busy, 1);
        rst = 1'b0;
        #1;
        bus.ls_req_valid  = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h7777_7777;
        #1;
        chk("rstmid busy", busy, 0);
        chk("rstmid ls_rsp", bus.ls_rsp_valid, 0);
        chk("rstmid ls_rdata", bus.ls_rsp_rdata, 0);
        chk("rstmid ls_ready", bus.ls_req_ready, 0);
        chk("rstmid mem_valid", bus.mem_req_valid, 0);
        chk("rstmid mem_addr", bus.mem_req_addr, 0);
        cyc;
        #1;
        chk("rstmid held_busy", busy, 0);
        cyc;
        drive_ls(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'h0;
        rst = 1'b1;

        fresh = '{1'b0, 1'b0, 4'h0, 32'h0000_0080, 32'h0, 32'h0000_0013, 0, 0,
                  1'b0, 4'hF, 32'h0, 32'h0000_0013};
        run_vec(fresh, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port memory inside processor_top.
- Shares the port between instruction fetch (IF) and load/store (LS): one outstanding transaction, a registered memory request, response routed back to the owner, and a response timeout that reports an error.
- Sits between the core pipeline and the memory model instantiated by the processor testbench.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8.
- TIMEOUT, 15, maximum cycles spent in WAIT_RSP before an error response (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  ADDR_W  fetch address.
- if_req_ready  out  1  fetch request captured this cycle.
- if_rsp_valid  out  1  fetch response, one-cycle pulse.
- if_rsp_rdata  out  DATA_W  fetch read data.
- if_rsp_err  out  1  fetch timed out.
- ls_req_valid  in  1  load/store request.
- ls_req_we  in  1  1 = store.
- ls_req_be  in  BE_W  byte enables.
- ls_req_addr  in  ADDR_W  load/store address.
- ls_req_wdata  in  DATA_W  store data.
- ls_req_ready  out  1  load/store request captured this cycle.
- ls_rsp_valid  out  1  load/store response pulse.
- ls_rsp_rdata  out  DATA_W  load data.
- ls_rsp_err  out  1  load/store timed out.
- mem_req_valid  out  1  memory request.
- mem_req_we  out  1  memory write.
- mem_req_be  out  BE_W  memory byte enables.
- mem_req_addr  out  ADDR_W  memory address.
- mem_req_wdata  out  DATA_W  memory write data.
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  memory read data / write ack.
- mem_rsp_rdata  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, owner=IF, last_owner=IF, timeout counter=0, all mem_req_* fields=0. All outputs 0. Any in-flight transaction is dropped with no response.
- States:
  - IDLE → ISSUE when either req_valid is high.
  - ISSUE → WAIT_RSP on mem_req_valid && mem_req_ready.
  - WAIT_RSP → IDLE on mem_rsp_valid, or when the timeout counter reaches TIMEOUT.
- IDLE:
  - Pick the winner (see priority). Assert the winner's req_ready combinationally in the same cycle.
  - Capture addr/we/be/wdata into registers. IF requests capture we=0, be=all-ones, wdata=0.
  - Set owner. Next cycle is ISSUE.
- ISSUE:
  - mem_req_valid=1 driven from registers; fields stable until accepted.
  - No new req_ready is given to either requester.
- WAIT_RSP:
  - Counter increments each cycle and is cleared on entry.
  - On mem_rsp_valid: owner's rsp_valid=1 the same cycle, rsp_rdata=mem_rsp_rdata, rsp_err=0, update last_owner, go to IDLE.
  - If the counter reaches TIMEOUT first: owner's rsp_valid=1, rsp_err=1, rsp_rdata=0, go to IDLE.
  - A mem_rsp_valid arriving after a timeout is ignored.
- Responses to the non-owner stay 0. rsp_rdata is 0 whenever rsp_valid=0.
- mem_rsp_valid in IDLE or ISSUE is ignored; memory must respond ≥1 cycle after acceptance.
- Stores also complete through mem_rsp_valid (write ack); ls_rsp_rdata is undefined-but-forwarded for stores.
- Latency: minimum 3 cycles from req_ready to rsp_valid (capture, issue/accept, response). Back-to-back throughput is one transaction per 3 cycles minimum.
- Default priority (fixed): LS wins when both are valid. IF may starve under continuous LS traffic.
- Requester must hold req_valid and its fields until req_ready; dropping valid before capture is legal and loses nothing.

Optional Feature:
- Macro: RV32_ARB_ROUND_ROBIN_EN.
- Defined: when both are valid in IDLE, grant the requester that is not last_owner. A single valid requester is always granted. last_owner updates on every completed response, including errors.
- Undefined: fixed LS priority; last_owner register is removed.

Decomposition:
- Package rv32_bus_pkg holds:
  - state enum {IDLE, ISSUE, WAIT_RSP};
  - owner enum {OWN_IF, OWN_LS};
  - BE_W derivation;
  - default ADDR_W/DATA_W constants.
- One sub-module: rv32_arb_pick, a 2-way grant picker (inputs: valids, last_owner; output: winner), containing the RV32_ARB_ROUND_ROBIN_EN logic.

Test Plan:
- Single fetch:
  - Stimulus: if_req_valid, addr=0x0000_0010; memory ready immediately, responds 1 cycle later with 0x0050_0093.
  - Expected: if_req_ready at cycle 0; mem_req_valid at cycle 1; if_rsp_valid at cycle 2 with that data and err=0.
- Simultaneous requests:
  - Stimulus: IF addr 0x20 and LS load addr 0x100 both valid.
  - Expected without the macro: LS served first, IF second.
  - Expected with the macro after an LS-last history: IF served first.
- Store:
  - Stimulus: ls_req_we=1, be=4'b0011, addr=0x104, wdata=0xDEAD_BEEF.
  - Expected: mem_req_* carries the exact values; ls_rsp_valid pulses on the ack.
- Backpressure:
  - Stimulus: mem_req_ready held low 4 cycles.
  - Expected: mem_req_addr/wdata stable throughout; no req_ready to either requester; completion after ready rises.
- Timeout:
  - Stimulus: memory never responds, TIMEOUT=15.
  - Expected: owner's rsp_valid=1, rsp_err=1, rdata=0 exactly 15 cycles after entering WAIT_RSP; a late mem_rsp_valid is ignored.
- Reset mid-transaction:
  - Stimulus: assert rst=0 during WAIT_RSP.
  - Expected: busy=0 and all outputs 0 immediately (async). After release, a fresh fetch completes normally.
